// File: rtl/normalizer32.sv
// -----------------------------------------------------------------------------
// normalizer32 -- iterative 32-bit normalizer (leading-zero / redundant-sign
// count plus left shift).
//
// An accepted start loads the operand into a work register. Five RUN cycles
// follow, and each one tries a binary-search shift of 16, 8, 4, 2 and then 1
// bits. The shift is taken only if it would discard nothing significant:
//   unsigned: the top s bits are all zero.
//   signed  : the top s+1 bits are all equal, so the sign bit survives.
// The shift amounts sum to 31, so the count fits in 5 bits and needs no
// saturation logic.
//
// Ports
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request a normalization (ignored while busy)
//   a      in  32  operand, sampled on an accepted start
//   mode   in   1  0 = unsigned (leading zeros), 1 = signed (redundant signs)
//   busy   out  1  high during the five RUN cycles
//   done   out  1  one-cycle result-valid pulse (DONE state)
//   c      out 32  normalized operand, held until the next result
//   cnt    out  5  shift amount applied, held until the next result
//   zero   out  1  operand was zero, updated on each accepted start
// -----------------------------------------------------------------------------
module normalizer32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] c,
  output logic [4:0]  cnt,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_work;
  logic [4:0]  r_count;
  logic [2:0]  r_step;
  logic        r_mode;
  logic        r_busy;
  logic        r_done;
  logic        r_zero;
  logic [31:0] r_c;
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic        w_take;
  logic [4:0]  w_shamt;
  logic [31:0] w_work_nxt;
  logic [4:0]  w_count_nxt;

  // A start arriving during RUN is dropped without any side effect. A start
  // in DONE is taken, which gives one result every six cycles.
  assign w_accept = start && (r_state != RUN);

  // Evaluate one binary-search step on the current work register.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    w_take  = 1'b0;
    w_shamt = 5'd0;
    case (r_step)
      3'd0: begin
        w_shamt = 5'd16;
        w_take  = r_mode ? ((r_work[31:15] == '0) || (r_work[31:15] == '1))
                         : (r_work[31:16] == '0);
      end
      3'd1: begin
        w_shamt = 5'd8;
        w_take  = r_mode ? ((r_work[31:23] == '0) || (r_work[31:23] == '1))
                         : (r_work[31:24] == '0);
      end
      3'd2: begin
        w_shamt = 5'd4;
        w_take  = r_mode ? ((r_work[31:27] == '0) || (r_work[31:27] == '1))
                         : (r_work[31:28] == '0);
      end
      3'd3: begin
        w_shamt = 5'd2;
        w_take  = r_mode ? ((r_work[31:29] == '0) || (r_work[31:29] == '1))
                         : (r_work[31:30] == '0);
      end
      3'd4: begin
        w_shamt = 5'd1;
        w_take  = r_mode ? (r_work[31] == r_work[30]) : !r_work[31];
      end
      default: begin
        w_take  = 1'b0;
        w_shamt = 5'd0;
      end
    endcase
    w_work_nxt  = w_take ? (r_work << w_shamt) : r_work;
    // The five amounts sum to 31, so this sum cannot overflow 5 bits.
    w_count_nxt = w_take ? (r_count + w_shamt) : r_count;
  end

  // Single-process FSM. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_step  <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_c     <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values; a later assignment in this block overrides an
      // earlier one, which the start handling below relies on.
      r_done <= 1'b0;
      case (r_state)
        IDLE: r_state <= IDLE;
        RUN: begin
          r_work  <= w_work_nxt;
          r_count <= w_count_nxt;
          r_step  <= r_step + 3'd1;
          if (r_step == 3'd4) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_c     <= w_work_nxt;
            r_cnt   <= w_count_nxt;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Takes priority over the DONE->IDLE return. The c/cnt registers are not
      // touched here, so the previous result stays visible through the next RUN.
      if (w_accept) begin
        r_work  <= a;
        r_count <= '0;
        r_step  <= '0;
        r_mode  <= mode;
        r_zero  <= (a == 32'h0);
        r_state <= RUN;
        r_busy  <= 1'b1;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign c    = r_c;
  assign cnt  = r_cnt;
  assign zero = r_zero;

endmodule

// File: tb/tb_normalizer32.sv
// -----------------------------------------------------------------------------
// tb_normalizer32 -- directed self-checking bench for normalizer32.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a cycle away from the rising edge the DUT uses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_normalizer32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic        mode;
  logic        busy;
  logic        done;
  logic [31:0] c;
  logic [4:0]  cnt;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  normalizer32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .cnt   (cnt),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start at the current falling edge. It is sampled on the next
  // rising edge. The task returns at the following falling edge, which is the
  // first RUN cycle, with start released.
  task automatic start_op(input logic [31:0] op, input logic md);
    start = 1'b1;
    a     = op;
    mode  = md;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first RUN cycle. Waits (bounded) for done, then checks the
  // latency, the busy length and the results. With 'glitch' set, a second
  // start with a = 1 is presented during RUN and must be ignored. With
  // 'linger' set, it also checks that done drops and the results hold.
  task automatic wait_done(input string tag, input logic [31:0] ec, input logic [4:0] ecnt,
                           input logic ez, input bit glitch, input bit linger);
    int lat = 0;
    int nb  = 0;
    if (busy) nb++;
    if (glitch) begin
      start = 1'b1;
      a     = 32'h0000_0001;
      mode  = 1'b0;
    end
    while (!done && lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nb++;
    end
    check({tag, " latency"}, lat, 5);
    check({tag, " busy_cycles"}, nb, 5);
    check({tag, " c"}, c, ec);
    check({tag, " cnt"}, {27'd0, cnt}, {27'd0, ecnt});
    check({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
    if (linger) begin
      @(negedge clk);
      check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, " c_held"}, c, ec);
    end
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    mode  = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst c",    c,             32'd0);
    check("rst cnt",  {27'd0, cnt},  32'd0);
    check("rst zero", {31'd0, zero}, 32'd0);

    // Release reset and present start together, so it is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h0000_0001, 1'b0);
    wait_done("u_one", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b1);

    start_op(32'h00F0_0000, 1'b0);
    wait_done("u_00f0", 32'hF000_0000, 5'd8, 1'b0, 1'b0, 1'b1);

    start_op(32'h0000_0000, 1'b0);
    wait_done("u_zero", 32'h0000_0000, 5'd31, 1'b1, 1'b0, 1'b1);

    start_op(32'hFFFF_8000, 1'b1);
    wait_done("s_ffff8000", 32'h8000_0000, 5'd16, 1'b0, 1'b0, 1'b1);

    start_op(32'h0000_3000, 1'b1);
    wait_done("s_3000", 32'h6000_0000, 5'd17, 1'b0, 1'b0, 1'b1);

    start_op(32'h0000_0000, 1'b1);
    wait_done("s_zero", 32'h0000_0000, 5'd31, 1'b1, 1'b0, 1'b1);

    start_op(32'hFFFF_FFFF, 1'b1);
    wait_done("s_ones", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b1);

    // Already-normalized operands still take the full RUN and return cnt = 0.
    start_op(32'h8000_0000, 1'b0);
    wait_done("u_norm", 32'h8000_0000, 5'd0, 1'b0, 1'b0, 1'b1);

    start_op(32'h4000_0000, 1'b1);
    wait_done("s_norm", 32'h4000_0000, 5'd0, 1'b0, 1'b0, 1'b1);

    start_op(32'hB000_0000, 1'b1);
    wait_done("s_neg_norm", 32'hB000_0000, 5'd0, 1'b0, 1'b0, 1'b1);

    // A second start during RUN is ignored.
    start_op(32'h0000_0100, 1'b0);
    wait_done("u_glitch", 32'h8000_0000, 5'd23, 1'b0, 1'b1, 1'b0);

    // Back-to-back: a start in DONE is accepted and the previous result is
    // still shown in the first RUN cycle of the new operation.
    start_op(32'h4000_0000, 1'b0);
    check("b2b prev_c",   c,             32'h8000_0000);
    check("b2b prev_cnt", {27'd0, cnt},  32'd23);
    check("b2b busy",     {31'd0, busy}, 32'd1);
    wait_done("u_b2b", 32'h8000_0000, 5'd1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of RUN clears outputs without a clock edge, and no
    // done pulse follows.
    start_op(32'h0000_0000, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst c",    c,             32'd0);
    check("arst cnt",  {27'd0, cnt},  32'd0);
    check("arst zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst no_done", nd, 0);
    check("arst idle_busy", {31'd0, busy}, 32'd0);

    // A normal operation after the aborted one.
    start_op(32'h0001_2345, 1'b0);
    wait_done("u_after_rst", 32'h91A2_8000, 5'd15, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
